output_stream_collector: RTL and testbench
==========================================

Name: output_stream_collector

Overview:
- Consumes result bursts from the convolution controller: one output_valid pulse per cycle, each with a LANES-wide accumulator word from the output shift stage plus output_x/output_y/output_ch tags.
- Buffers bursts in a FIFO and serializes each word into one-lane-per-beat transfers on a valid/ready host interface.
- Gives the controller early backpressure through almost_full.
- Sits directly downstream of the controller/ODS datapath, in front of the external testbench/host link.

Parameters:
- ACC_WIDTH, 32, width of one accumulator lane
- LANES, 3, accumulator values per input word (ODS shift width)
- DEPTH, 8, FIFO entries (power of two, >=4)
- TAG_WIDTH, 32, width of the x/y/ch tags

Ports:
- clk  in  1  clock
- arst_in  in  1  asynchronous reset, active-high
- clear  in  1  synchronous flush of FIFO, serializer and counters
- in_valid  in  1  word present this cycle (controller output_valid)
- in_data  in  LANES*ACC_WIDTH  lane 0 in LSBs
- in_x  in  TAG_WIDTH  output x tag
- in_y  in  TAG_WIDTH  output y tag
- in_ch  in  TAG_WIDTH  base output channel of lane 0
- almost_full  out  1  count >= DEPTH-2
- overflow  out  1  sticky: a word was dropped
- out_valid  out  1  host beat valid
- out_ready  in  1  host accepts beat
- out_data  out  ACC_WIDTH  current lane value
- out_x  out  TAG_WIDTH  x of current beat
- out_y  out  TAG_WIDTH  y of current beat
- out_ch  out  TAG_WIDTH  in_ch + lane index
- out_last_lane  out  1  current beat is lane LANES-1
- beats_sent  out  32  count of completed host beats

Behaviour:
- Reset (arst_in=1, asynchronous):
  - FIFO empty, rd/wr pointers 0, lane counter 0, state IDLE.
  - out_valid=0, out_data/out_x/out_y/out_ch=0, out_last_lane=0.
  - overflow=0, almost_full=0, beats_sent=0.
  - Reset mid-transfer drops all buffered data with no further beats.
- FIFO:
  - Entry = {in_ch, in_y, in_x, in_data}.
  - count tracks occupancy 0..DEPTH, pointers wrap modulo DEPTH.
- Push accept rule:
  - Accepted when in_valid and (count<DEPTH, or a pop completes in the same cycle).
  - in_valid while full with no pop: word dropped, overflow set (sticky until reset/clear), count unchanged.
- Pop: an entry is freed on the cycle its last lane is accepted (out_valid & out_ready & out_last_lane).
- Simultaneous push and pop: count unchanged, both pointers advance.
- almost_full: registered, updated from next-count. Two cycles of margin cover the controller's two-beat output burst.
- Serializer FSM:
  - IDLE: out_valid=0. If count>0 (registered occupancy), load head entry into output holding regs, lane=0, go EMIT. First beat appears the cycle after the entry is resident, so minimum latency in_valid→out_valid is 2 cycles.
  - EMIT: out_valid=1; out_data=lane slice [lane*ACC_WIDTH +: ACC_WIDTH]; out_ch=tag_ch+lane (TAG_WIDTH wrap); out_last_lane=(lane==LANES-1).
  - On out_valid & out_ready:
    - not last lane: lane++.
    - last lane: pop. If another entry remains (count-1>0, or a push this cycle makes it nonzero next), load the next head directly, lane=0, stay EMIT with no bubble. Otherwise go IDLE.
  - Outputs hold stable while out_valid & !out_ready (AXI-style; no withdrawal or change).
- beats_sent increments on every accepted beat and wraps at 2^32.
- clear (synchronous): same effect as reset except it is sampled on the clock edge. If clear and in_valid coincide, clear wins and the word is not stored.
- No combinational path from out_ready to in-side signals. almost_full and overflow are registered.

Test Plan:
- Single word: in_valid 1 cycle, in_data={30,20,10}, x=4,y=7,ch=6, out_ready=1. Required: out_valid rises 2 cycles later; beats (10,ch6),(20,ch7),(30,ch8) on consecutive cycles; out_last_lane only on the third beat; beats_sent=3; FIFO empty.
- Backpressure: same word, out_ready=0 for 5 cycles then 1. Required: out_data=10 and tags held stable for the stalled cycles; then all 3 beats in order.
- Fill and overflow: out_ready=0, 8 in_valid pulses. Required: almost_full asserts after the 6th push; count=8; a 9th pulse leaves overflow=1 and FIFO contents unchanged. Release out_ready: 24 beats emitted, matching the first 8 words.
- Back-to-back: 4 consecutive words, out_ready=1 throughout. Required: 12 beats with no idle cycle between words.
- Full with simultaneous pop: FIFO full, last lane accepted in the same cycle as in_valid. Required: word stored, overflow stays 0, count stays 8.
- Reset/clear mid-stream: assert arst_in (async, between edges) during lane 1 of the 2nd of 3 words. Required: out_valid=0 immediately; beats_sent=0; no beats after release. Repeat with clear: identical result on the next edge.

Source files
------------

// File: rtl/output_stream_collector.sv
// output_stream_collector
//   Buffers accumulator words from the convolution controller in a FIFO and
//   serializes each word into one-lane-per-beat transfers on a valid/ready
//   host link.
// Ports:
//   clk, arst_in       clock, asynchronous active-high reset
//   clear              synchronous flush of FIFO, serializer and counters
//   in_valid/in_data   incoming word (lane 0 in LSBs) with in_x/in_y/in_ch tags
//   almost_full        registered, occupancy >= DEPTH-2
//   overflow           sticky, a word arrived while full and was dropped
//   out_valid/out_ready host handshake; out_data/out_x/out_y/out_ch per beat
//   out_last_lane      current beat is lane LANES-1
//   beats_sent         count of accepted host beats (wraps)
module output_stream_collector #(
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned LANES     = 3,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned TAG_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       arst_in,
    input  logic                       clear,
    input  logic                       in_valid,
    input  logic [LANES*ACC_WIDTH-1:0] in_data,
    input  logic [TAG_WIDTH-1:0]       in_x,
    input  logic [TAG_WIDTH-1:0]       in_y,
    input  logic [TAG_WIDTH-1:0]       in_ch,
    output logic                       almost_full,
    output logic                       overflow,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_WIDTH-1:0]       out_data,
    output logic [TAG_WIDTH-1:0]       out_x,
    output logic [TAG_WIDTH-1:0]       out_y,
    output logic [TAG_WIDTH-1:0]       out_ch,
    output logic                       out_last_lane,
    output logic [31:0]                beats_sent
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned DW = LANES * ACC_WIDTH;
    localparam int unsigned EW = DW + 3 * TAG_WIDTH;

    localparam logic [CW-1:0] CountFull = CW'(DEPTH);
    localparam logic [CW-1:0] AfThresh  = CW'(DEPTH - 2);
    localparam logic [LW-1:0] LastLane  = LW'(LANES - 1);
    localparam logic [PW-1:0] PtrOne    = PW'(1);

    typedef enum logic [0:0] {StIdle, StEmit} state_e;

    logic [EW-1:0]        mem [DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q, count_d;
    logic [LW-1:0]        lane_q;
    state_e               state_q;
    logic [DW-1:0]        data_q;
    logic [TAG_WIDTH-1:0] x_q, y_q, ch_q;
    logic                 almost_full_q, overflow_q;
    logic [31:0]          beats_q;

    logic          emit, last, accept, pop, push, next_avail;
    logic [EW-1:0] in_word, head_word, next_word;

    assign in_word   = {in_ch, in_y, in_x, in_data};
    assign head_word = mem[rd_ptr_q];
    // With a single resident entry the next head is the word arriving this cycle.
    assign next_word = (count_q > CW'(1)) ? mem[rd_ptr_q + PtrOne] : in_word;

    always_comb begin
        emit       = (state_q == StEmit);
        last       = emit && (lane_q == LastLane);
        accept     = emit && out_ready;
        pop        = accept && last;
        push       = in_valid && !clear && ((count_q != CountFull) || pop);
        next_avail = (count_q > CW'(1)) || push;
        count_d    = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage has no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_word;
        end
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            lane_q        <= '0;
            state_q       <= StIdle;
            data_q        <= '0;
            x_q           <= '0;
            y_q           <= '0;
            ch_q          <= '0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
            beats_q       <= '0;
        end else if (clear) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            lane_q        <= '0;
            state_q       <= StIdle;
            data_q        <= '0;
            x_q           <= '0;
            y_q           <= '0;
            ch_q          <= '0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
            beats_q       <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
            count_q       <= count_d;
            almost_full_q <= (count_d >= AfThresh);
            if (in_valid && !push) overflow_q <= 1'b1;
            if (accept) beats_q <= beats_q + 32'd1;

            unique case (state_q)
                StIdle: begin
                    if (count_q != '0) begin
                        {ch_q, y_q, x_q, data_q} <= head_word;
                        lane_q                   <= '0;
                        state_q                  <= StEmit;
                    end
                end
                StEmit: begin
                    if (accept) begin
                        if (!last) begin
                            lane_q <= lane_q + LW'(1);
                        end else if (next_avail) begin
                            {ch_q, y_q, x_q, data_q} <= next_word;
                            lane_q                   <= '0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        out_valid     = emit;
        out_data      = emit ? data_q[lane_q*ACC_WIDTH +: ACC_WIDTH] : '0;
        out_x         = emit ? x_q : '0;
        out_y         = emit ? y_q : '0;
        out_ch        = emit ? ch_q + TAG_WIDTH'(lane_q) : '0;
        out_last_lane = last;
    end

    assign almost_full = almost_full_q;
    assign overflow    = overflow_q;
    assign beats_sent  = beats_q;

endmodule

// File: tb/tb_output_stream_collector.sv
module tb_output_stream_collector;

    localparam int ACC = 32;
    localparam int LANES = 3;
    localparam int DEPTH = 8;
    localparam int TW = 32;

    logic              clk = 1'b0;
    logic              arst_in = 1'b1;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic [LANES*ACC-1:0] in_data = '0;
    logic [TW-1:0]     in_x = '0, in_y = '0, in_ch = '0;
    logic              almost_full, overflow, out_valid;
    logic              out_ready = 1'b0;
    logic [ACC-1:0]    out_data;
    logic [TW-1:0]     out_x, out_y, out_ch;
    logic              out_last_lane;
    logic [31:0]       beats_sent;

    output_stream_collector #(
        .ACC_WIDTH(ACC), .LANES(LANES), .DEPTH(DEPTH), .TAG_WIDTH(TW)
    ) dut (
        .clk(clk), .arst_in(arst_in), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
        .almost_full(almost_full), .overflow(overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_x(out_x), .out_y(out_y), .out_ch(out_ch),
        .out_last_lane(out_last_lane), .beats_sent(beats_sent)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ACC-1:0] data;
        logic [TW-1:0]  x;
        logic [TW-1:0]  y;
        logic [TW-1:0]  ch;
        logic           last;
    } beat_t;

    beat_t sb[$];
    int n_checks = 0;
    int n_fail = 0;

    // Valid-cycle tracking for the back-to-back test.
    bit track = 1'b0;
    int cyc = 0, first_hi = -1, last_hi = -1, n_hi = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Drive one word for one clock edge; queue its expected beats when it should be kept.
    task automatic send(input logic [TW-1:0] x, input logic [TW-1:0] y, input logic [TW-1:0] ch,
                        input logic [ACC-1:0] d0, input logic [ACC-1:0] d1,
                        input logic [ACC-1:0] d2, input bit keep);
        in_x = x; in_y = y; in_ch = ch; in_data = {d2, d1, d0}; in_valid = 1'b1;
        if (keep) begin
            sb.push_back('{data: d0, x: x, y: y, ch: ch,       last: 1'b0});
            sb.push_back('{data: d1, x: x, y: y, ch: ch + 32'd1, last: 1'b0});
            sb.push_back('{data: d2, x: x, y: y, ch: ch + 32'd2, last: 1'b1});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int i = 0;
        while (sb.size() != 0 && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        check(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Scoreboard monitor: a beat presented with ready high is accepted on the next edge.
    always @(negedge clk) begin
        beat_t got, exp_b;
        cyc++;
        if (track && out_valid) begin
            if (first_hi < 0) first_hi = cyc;
            last_hi = cyc;
            n_hi++;
        end
        if (!arst_in && !clear && out_valid && out_ready) begin
            got = '{data: out_data, x: out_x, y: out_y, ch: out_ch, last: out_last_lane};
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL beat_unexpected: got data=%0d x=%0d ch=%0d, required no beat",
                         out_data, out_x, out_ch);
            end else begin
                exp_b = sb.pop_front();
                if (got !== exp_b) begin
                    n_fail++;
                    $display("FAIL beat: got data=%0d x=%0d y=%0d ch=%0d last=%0d, required data=%0d x=%0d y=%0d ch=%0d last=%0d",
                             got.data, got.x, got.y, got.ch, got.last,
                             exp_b.data, exp_b.x, exp_b.y, exp_b.ch, exp_b.last);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    // Mid-stream abort: 3 words, abort during lane 1 of the 2nd.
    task automatic abort_mid(input bit use_reset);
        int i;
        int vis;
        bit found;
        out_ready = 1'b1;
        send(32'd80, 32'd1, 32'd10, 32'd1, 32'd2, 32'd3, 1'b1);
        send(32'd81, 32'd1, 32'd10, 32'd4, 32'd5, 32'd6, 1'b1);
        send(32'd82, 32'd1, 32'd10, 32'd7, 32'd8, 32'd9, 1'b1);
        found = 1'b0;
        for (i = 0; i < 20 && !found; i++) begin
            if (out_valid && out_x == 32'd81 && out_ch == 32'd11) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check(use_reset ? "rst_find_lane1" : "clr_find_lane1", 64'(found), 64'd1);
        if (use_reset) begin
            #2 arst_in = 1'b1;
            #1;
        end else begin
            clear = 1'b1;
            @(posedge clk); #1;
        end
        check(use_reset ? "rst_out_valid" : "clr_out_valid", 64'(out_valid), 64'd0);
        check(use_reset ? "rst_beats_sent" : "clr_beats_sent", 64'(beats_sent), 64'd0);
        sb.delete();
        if (use_reset) begin
            @(posedge clk); #1;
            arst_in = 1'b0;
        end else begin
            clear = 1'b0;
        end
        vis = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) vis++;
        end
        check(use_reset ? "rst_no_beats_after" : "clr_no_beats_after", 64'(vis), 64'd0);
        check(use_reset ? "rst_count" : "clr_count", 64'(dut.count_q), 64'd0);
    endtask

    initial begin
        bit found;
        logic [ACC-1:0] held_d;
        logic [TW-1:0]  held_x, held_y, held_ch;

        // Reset state while reset is held.
        #3;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_out_ch", 64'(out_ch), 64'd0);
        check("reset_last_lane", 64'(out_last_lane), 64'd0);
        check("reset_almost_full", 64'(almost_full), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        check("reset_beats_sent", 64'(beats_sent), 64'd0);
        @(posedge clk); #1;
        arst_in = 1'b0;
        step(2);

        // Single word: out_valid rises two cycles after in_valid.
        out_ready = 1'b1;
        send(32'd4, 32'd7, 32'd6, 32'd10, 32'd20, 32'd30, 1'b1);
        check("single_lat1", 64'(out_valid), 64'd0);
        step(1);
        check("single_lat2", 64'(out_valid), 64'd1);
        step(1);
        check("single_beat2_valid", 64'(out_valid), 64'd1);
        step(1);
        check("single_beat3_valid", 64'(out_valid), 64'd1);
        step(1);
        check("single_done_valid", 64'(out_valid), 64'd0);
        check("single_beats_sent", 64'(beats_sent), 64'd3);
        check("single_count", 64'(dut.count_q), 64'd0);
        check("single_sb_empty", 64'(sb.size()), 64'd0);

        // Backpressure: first beat held stable for 5 stalled cycles.
        out_ready = 1'b0;
        send(32'd4, 32'd7, 32'd6, 32'd10, 32'd20, 32'd30, 1'b1);
        step(1);
        check("bp_valid", 64'(out_valid), 64'd1);
        held_d = out_data; held_x = out_x; held_y = out_y; held_ch = out_ch;
        check("bp_data", 64'(held_d), 64'd10);
        repeat (5) begin
            step(1);
            check("bp_hold", {out_valid, out_data, out_ch[30:0]},
                  {1'b1, held_d, held_ch[30:0]});
            check("bp_hold_xy", {out_x, out_y}, {held_x, held_y});
        end
        out_ready = 1'b1;
        drain("bp_drain", 10);
        check("bp_beats_sent", 64'(beats_sent), 64'd6);

        // Fill and overflow.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(32'(20 + i), 32'(i), 32'(3 * i), 32'(100 * i + 1), 32'(100 * i + 2),
                 32'(100 * i + 3), 1'b1);
            check("fill_almost_full", 64'(almost_full), (i >= 5) ? 64'd1 : 64'd0);
        end
        check("fill_count", 64'(dut.count_q), 64'd8);
        check("fill_overflow_pre", 64'(overflow), 64'd0);
        send(32'd999, 32'd999, 32'd999, 32'd9, 32'd9, 32'd9, 1'b0);
        check("ovf_overflow", 64'(overflow), 64'd1);
        check("ovf_count", 64'(dut.count_q), 64'd8);
        out_ready = 1'b1;
        drain("ovf_drain", 40);
        check("ovf_beats_sent", 64'(beats_sent), 64'd30);
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Clear pulse while idle.
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("clear_overflow", 64'(overflow), 64'd0);
        check("clear_beats_sent", 64'(beats_sent), 64'd0);
        check("clear_almost_full", 64'(almost_full), 64'd0);

        // Back-to-back words: 12 beats with no idle cycle.
        first_hi = -1; last_hi = -1; n_hi = 0; track = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(32'(40 + i), 32'd2, 32'(8 * i), 32'(i + 1), 32'(i + 11), 32'(i + 21), 1'b1);
        end
        drain("b2b_drain", 20);
        step(2);
        track = 1'b0;
        check("b2b_valid_cycles", 64'(n_hi), 64'd12);
        check("b2b_contiguous", 64'(last_hi - first_hi), 64'd11);
        check("b2b_beats_sent", 64'(beats_sent), 64'd12);

        // Full with a pop in the same cycle as the push.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(32'(60 + i), 32'd3, 32'd0, 32'(i), 32'(i + 50), 32'(i + 90), 1'b1);
        end
        check("fp_count_full", 64'(dut.count_q), 64'd8);
        out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk); #1;
            if (out_last_lane) found = 1'b1;
        end
        check("fp_find_last", 64'(found), 64'd1);
        send(32'd77, 32'd5, 32'd40, 32'd500, 32'd501, 32'd502, 1'b1);
        check("fp_overflow", 64'(overflow), 64'd0);
        check("fp_count", 64'(dut.count_q), 64'd8);
        drain("fp_drain", 40);

        abort_mid(1'b1);
        abort_mid(1'b0);

        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
